// File: rtl/dsm_modulator_if.sv
`default_nettype none
// ============================================================================
// Module   : dsm_modulator_if
// Purpose  : PCM sample handshake between a sample source and the
//            delta-sigma modulator.
// Signals  : in_data  - signed 16-bit PCM sample (two's complement)
//            in_valid - in_data is valid this cycle
//            in_ready - modulator can accept a sample this cycle
// Modports : master (sample source), slave (modulator)
// Revision : 1.0 - initial release
// ============================================================================
interface dsm_modulator_if;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/dsm_modulator.sv
`default_nettype none
// ============================================================================
// Module   : dsm_modulator
// Purpose  : Second-order 1-bit delta-sigma modulator. Takes one 16-bit
//            signed PCM sample per OSR-cycle frame and emits one bit per
//            clk, noise shaped by (1 - z^-1)^2.
// Params   : OSR - clk cycles per input sample (>= 2)
//            EW  - width of the signed error registers e1/e2
// Ports    : clk          - clock, rising edge
//            rst_n        - synchronous active-low reset
//            in_if        - sample handshake (slave side)
//            dsm_out      - registered bitstream, 1 = +FS, 0 = -FS
//            frame_strobe - one-cycle pulse after each frame boundary
//            underrun     - pulse with frame_strobe when no sample was pending
// Revision : 1.0 - initial release
// ============================================================================
module dsm_modulator #(
    parameter int OSR = 64,
    parameter int EW  = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    dsm_modulator_if.slave in_if,
    output logic           dsm_out,
    output logic           frame_strobe,
    output logic           underrun
);
    localparam int CW = $clog2(OSR);
    localparam int UW = EW + 2;   // loop input u
    localparam int DW = EW + 3;   // y - u before saturation

    localparam logic [CW-1:0]        c_cnt_last  = CW'(OSR - 1);
    localparam logic signed [15:0]   c_clamp_pos = 16'sd24576;
    localparam logic signed [15:0]   c_clamp_neg = -16'sd24576;
    localparam logic signed [DW-1:0] c_y_pos     = DW'(32768);
    localparam logic signed [DW-1:0] c_y_neg     = -c_y_pos;
    localparam logic signed [DW-1:0] c_e_max     = DW'((1 << (EW - 1)) - 1);
    localparam logic signed [DW-1:0] c_e_min     = ~c_e_max;

    logic [CW-1:0]        r_cnt;
    logic signed [15:0]   r_pending;
    logic                 r_pending_valid;
    logic signed [15:0]   r_active;
    logic signed [EW-1:0] r_e1;
    logic signed [EW-1:0] r_e2;

    logic                 w_boundary;
    logic                 w_accept;
    logic signed [15:0]   w_xc;
    logic signed [UW-1:0] w_u;
    logic                 w_pos;
    logic signed [DW-1:0] w_diff;
    logic signed [EW-1:0] w_e;

    // Single-entry buffer: ready only while empty, forced low in reset.
    assign in_if.in_ready = !r_pending_valid && rst_n;
    assign w_accept       = in_if.in_valid && !r_pending_valid;
    assign w_boundary     = (r_cnt == c_cnt_last);

    // Keep the modulator input within +-0.75 FS so the second-order loop
    // stays stable.
    always_comb begin
        w_xc = r_active;
        if (r_active > c_clamp_pos) begin
            w_xc = c_clamp_pos;
        end else if (r_active < c_clamp_neg) begin
            w_xc = c_clamp_neg;
        end
    end

    // u = xc - 2*e1 + e2, all operands sign-extended to UW bits.
    assign w_u = {{(UW - 16){w_xc[15]}}, w_xc}
               - {r_e1[EW-1], r_e1, 1'b0}
               + {{2{r_e2[EW-1]}}, r_e2};

    assign w_pos  = ~w_u[UW-1];
    assign w_diff = (w_pos ? c_y_pos : c_y_neg) - {w_u[UW-1], w_u};

    // Saturation of the quantisation error is a robustness guard only.
    always_comb begin
        w_e = w_diff[EW-1:0];
        if (w_diff > c_e_max) begin
            w_e = c_e_max[EW-1:0];
        end else if (w_diff < c_e_min) begin
            w_e = c_e_min[EW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_active        <= '0;
            r_e1            <= '0;
            r_e2            <= '0;
            dsm_out         <= 1'b0;
            frame_strobe    <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            r_e2         <= r_e1;
            r_e1         <= w_e;
            dsm_out      <= w_pos;
            frame_strobe <= w_boundary;
            underrun     <= w_boundary && !r_pending_valid;

            if (w_boundary) begin
                r_cnt <= '0;
                if (r_pending_valid) begin
                    r_active        <= r_pending;
                    r_pending_valid <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            // Acceptance needs an empty buffer, so it never collides with
            // the boundary drain above.
            if (w_accept) begin
                r_pending       <= in_if.in_data;
                r_pending_valid <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dsm_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsm_modulator
// Purpose  : Self-checking bench for dsm_modulator with a queue-based
//            behavioural reference model and scenario tasks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm_modulator;
    localparam int OSR = 64;
    localparam int EW  = 20;
    localparam int NF  = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic dsm_out, frame_strobe, underrun;

    dsm_modulator_if bus ();

    dsm_modulator #(.OSR(OSR), .EW(EW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_if        (bus),
        .dsm_out      (dsm_out),
        .frame_strobe (frame_strobe),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_edges;
    int m_pend [$];
    int m_active;
    int m_e1, m_e2;
    bit m_out, m_fs, m_ur;
    int acc_count;

    // Per-frame recordings, bit j = value after edge j of the frame
    logic [OSR-1:0] obs_bit [NF], mdl_bit [NF], save_bit [NF];
    logic [OSR-1:0] obs_fs  [NF], mdl_fs  [NF];
    logic [OSR-1:0] obs_ur  [NF], mdl_ur  [NF];
    logic [OSR-1:0] obs_rdy [NF], mdl_rdy [NF];
    logic [OSR-1:0] obs_acc [NF];

    localparam logic [OSR-1:0] LAST_BIT = {1'b1, {(OSR-1){1'b0}}};
    localparam logic [OSR-1:0] FIRST_BIT = {{(OSR-1){1'b0}}, 1'b1};

    function automatic int clamp(input int x);
        if (x > 24576)  return 24576;
        if (x < -24576) return -24576;
        return x;
    endfunction

    // One clock edge: sample inputs, advance the model, settle outputs.
    task automatic step();
        bit v, r, rdy;
        int d, u, y, e;
        v   = bus.in_valid;
        d   = bus.in_data;
        r   = rst_n;
        rdy = r && (m_pend.size() == 0);
        @(posedge clk);
        if (!r) begin
            m_edges = 0; m_pend.delete(); m_active = 0;
            m_e1 = 0; m_e2 = 0; m_out = 0; m_fs = 0; m_ur = 0;
        end else begin
            u = clamp(m_active) - 2 * m_e1 + m_e2;
            y = (u >= 0) ? 32768 : -32768;
            e = y - u;
            if (e > (1 << (EW-1)) - 1) e = (1 << (EW-1)) - 1;
            if (e < -(1 << (EW-1)))    e = -(1 << (EW-1));
            m_out = (u >= 0);
            m_e2  = m_e1;
            m_e1  = e;
            if (m_edges % OSR == OSR - 1) begin
                m_fs = 1;
                if (m_pend.size() > 0) begin
                    m_active = m_pend.pop_front();
                    m_ur = 0;
                end else begin
                    m_ur = 1;
                end
            end else begin
                m_fs = 0;
                m_ur = 0;
            end
            if (v && rdy) begin
                m_pend.push_back(d);
                acc_count++;
            end
            m_edges++;
        end
        #1;
    endtask

    // Stimulus driver. mode 0: hold v; 1: offer v once; 2: new random
    // sample after every accept; 3: random valid/data with random resets.
    task automatic stream(input int v, input int frames, input int mode, input bit do_reset);
        int a0;
        if (do_reset) begin
            rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
            step(); step();
            rst_n = 1'b1;
        end
        bus.in_valid = (mode != 3);
        bus.in_data  = 16'(v);
        for (int f = 0; f < frames; f++) begin
            for (int j = 0; j < OSR; j++) begin
                if (mode == 3) begin
                    rst_n        = ($urandom_range(0, 199) != 0);
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.in_data  = 16'($urandom);
                end
                #1;
                obs_acc[f][j] = bus.in_valid && bus.in_ready;
                a0 = acc_count;
                step();
                obs_bit[f][j] = dsm_out;      mdl_bit[f][j] = m_out;
                obs_fs[f][j]  = frame_strobe; mdl_fs[f][j]  = m_fs;
                obs_ur[f][j]  = underrun;     mdl_ur[f][j]  = m_ur;
                obs_rdy[f][j] = bus.in_ready; mdl_rdy[f][j] = rst_n && (m_pend.size() == 0);
                if (mode == 1) bus.in_valid = 1'b0;
                if (mode == 2 && acc_count != a0) bus.in_data = 16'($urandom);
            end
        end
        rst_n = 1'b1;
    endtask

    function automatic int ones(input int f0, input int f1);
        int s = 0;
        for (int f = f0; f <= f1; f++) s += $countones(obs_bit[f]);
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'sd1234;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({dsm_out, frame_strobe, underrun} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got %b expected 000", i, {dsm_out, frame_strobe, underrun});
            end
            n_vec++;
            if (bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL reset_ready cycle %0d: got %b expected 0", i, bus.in_ready);
            end
        end
        rst_n = 1'b1; bus.in_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release_ready: got %b expected 1", bus.in_ready);
        end
        for (int i = 0; i < OSR; i++) begin
            step();
            n_vec++;
            if (frame_strobe !== (i == OSR-1) || underrun !== (i == OSR-1)) begin
                n_err++;
                $display("FAIL first_boundary edge %0d: got fs=%b ur=%b expected %0d", i, frame_strobe, underrun, i == OSR-1);
            end
        end
    endtask

    task automatic test_zero();
        int c;
        stream(0, NF, 0, 1);
        for (int f = 0; f < NF; f++) begin
            n_vec++;
            if (obs_bit[f] !== mdl_bit[f] || obs_fs[f] !== mdl_fs[f]) begin
                n_err++;
                $display("FAIL zero_frame %0d: got %h/%h expected %h/%h", f, obs_bit[f], obs_fs[f], mdl_bit[f], mdl_fs[f]);
            end
            n_vec++;
            if (obs_ur[f] !== '0) begin
                n_err++;
                $display("FAIL zero_underrun frame %0d: got %h expected 0", f, obs_ur[f]);
            end
        end
        c = ones(1, NF-1);
        n_vec++;
        if (c < 2012 || c > 2020) begin
            n_err++;
            $display("FAIL zero_density: got %0d expected 2016+-4", c);
        end
    endtask

    task automatic test_half_scale();
        int c;
        for (int s = 0; s < 2; s++) begin
            stream((s == 0) ? 16384 : -16384, NF, 0, 1);
            for (int f = 0; f < NF; f++) begin
                n_vec++;
                if (obs_bit[f] !== mdl_bit[f]) begin
                    n_err++;
                    $display("FAIL half_bits sign %0d frame %0d: got %h expected %h", s, f, obs_bit[f], mdl_bit[f]);
                end
            end
            c = ones(1, NF-1);
            n_vec++;
            if ((s == 0 && (c < 3020 || c > 3028)) || (s == 1 && (c < 1004 || c > 1012))) begin
                n_err++;
                $display("FAIL half_density sign %0d: got %0d expected %0d+-4", s, c, (s == 0) ? 3024 : 1008);
            end
        end
    endtask

    task automatic test_clamp();
        int c;
        for (int s = 0; s < 2; s++) begin
            stream((s == 0) ? 32767 : -32768, 16, 0, 1);
            for (int f = 0; f < 16; f++) save_bit[f] = obs_bit[f];
            stream((s == 0) ? 24576 : -24576, 16, 0, 1);
            for (int f = 0; f < 16; f++) begin
                n_vec++;
                if (save_bit[f] !== obs_bit[f] || obs_bit[f] !== mdl_bit[f]) begin
                    n_err++;
                    $display("FAIL clamp_bits sign %0d frame %0d: got %h expected %h (model %h)", s, f, save_bit[f], obs_bit[f], mdl_bit[f]);
                end
            end
            c = ones(1, 15);
            n_vec++;
            if ((s == 0 && (c < 836 || c > 844)) || (s == 1 && (c < 116 || c > 124))) begin
                n_err++;
                $display("FAIL clamp_density sign %0d: got %0d expected %0d+-4", s, c, (s == 0) ? 840 : 120);
            end
        end
    endtask

    task automatic test_underrun();
        int c;
        stream(16384, 16, 1, 1);
        for (int f = 0; f < 16; f++) begin
            n_vec++;
            if (obs_ur[f] !== ((f == 0) ? '0 : LAST_BIT) || obs_fs[f] !== LAST_BIT) begin
                n_err++;
                $display("FAIL underrun_flags frame %0d: got ur=%h fs=%h expected ur=%h fs=%h",
                         f, obs_ur[f], obs_fs[f], (f == 0) ? '0 : LAST_BIT, LAST_BIT);
            end
            n_vec++;
            if (obs_bit[f] !== mdl_bit[f]) begin
                n_err++;
                $display("FAIL underrun_bits frame %0d: got %h expected %h", f, obs_bit[f], mdl_bit[f]);
            end
        end
        c = ones(1, 15);
        n_vec++;
        if (c < 716 || c > 724) begin
            n_err++;
            $display("FAIL underrun_density: got %0d expected 720+-4", c);
        end
    endtask

    task automatic test_back_to_back();
        stream(int'($urandom_range(0, 65535)) - 32768, 16, 2, 1);
        for (int f = 0; f < 16; f++) begin
            n_vec++;
            if (obs_acc[f] !== FIRST_BIT) begin
                n_err++;
                $display("FAIL accept_per_frame frame %0d: got %h expected %h", f, obs_acc[f], FIRST_BIT);
            end
            n_vec++;
            if (obs_rdy[f] !== LAST_BIT) begin
                n_err++;
                $display("FAIL ready_pattern frame %0d: got %h expected %h", f, obs_rdy[f], LAST_BIT);
            end
            n_vec++;
            if (obs_bit[f] !== mdl_bit[f] || obs_ur[f] !== '0) begin
                n_err++;
                $display("FAIL b2b_bits frame %0d: got %h ur=%h expected %h ur=0", f, obs_bit[f], obs_ur[f], mdl_bit[f]);
            end
        end
    endtask

    task automatic test_step_latency();
        int c;
        stream(0, 4, 0, 1);
        stream(16384, 8, 0, 0);
        for (int f = 0; f < 8; f++) begin
            n_vec++;
            if (obs_bit[f] !== mdl_bit[f]) begin
                n_err++;
                $display("FAIL step_bits frame %0d: got %h expected %h", f, obs_bit[f], mdl_bit[f]);
            end
        end
        c = ones(0, 0);
        n_vec++;
        if (c < 28 || c > 36) begin
            n_err++;
            $display("FAIL step_before: got %0d expected 32+-4", c);
        end
        c = ones(1, 7);
        n_vec++;
        if (c < 332 || c > 340) begin
            n_err++;
            $display("FAIL step_after: got %0d expected 336+-4", c);
        end
    endtask

    task automatic test_random();
        stream(0, 32, 3, 1);
        for (int f = 0; f < 32; f++) begin
            n_vec++;
            if (obs_bit[f] !== mdl_bit[f] || obs_fs[f] !== mdl_fs[f] || obs_ur[f] !== mdl_ur[f]) begin
                n_err++;
                $display("FAIL random_out frame %0d: got %h/%h/%h expected %h/%h/%h",
                         f, obs_bit[f], obs_fs[f], obs_ur[f], mdl_bit[f], mdl_fs[f], mdl_ur[f]);
            end
            n_vec++;
            if (obs_rdy[f] !== mdl_rdy[f]) begin
                n_err++;
                $display("FAIL random_ready frame %0d: got %h expected %h", f, obs_rdy[f], mdl_rdy[f]);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        m_edges = 0; m_active = 0; m_e1 = 0; m_e2 = 0;
        m_out = 0; m_fs = 0; m_ur = 0; acc_count = 0;
        test_reset();
        test_zero();
        test_half_scale();
        test_clamp();
        test_underrun();
        test_back_to_back();
        test_step_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
